// File: rtl/io_bus_ctrl.sv
// CPU-side bus controller: serves one access at a time to a bank of local
// registers or to one of NUM_CH external peripheral channels.
module io_bus_ctrl #(
    parameter int          NUM_CH    = 2,
    parameter int          REG_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1F80_1000,
    parameter int          CH_STRIDE = 16,
    parameter int          TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  data_i,
    input  logic                         wen,
    input  logic                         ren,
    input  logic [3:0]                   ben,
    output logic                         ack,
    output logic [31:0]                  data_o,
    output logic                         err,
    output logic [NUM_CH-1:0]            ch_req,
    output logic                         ch_we,
    output logic [$clog2(CH_STRIDE)-1:0] ch_addr,
    output logic [31:0]                  ch_wdata,
    output logic [3:0]                   ch_ben,
    input  logic [NUM_CH-1:0]            ch_ack,
    input  logic [32*NUM_CH-1:0]         ch_rdata
);

    localparam int          CA_W        = $clog2(CH_STRIDE);
    localparam int          RI_W        = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int          CI_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          CNT_W       = $clog2(TIMEOUT);
    localparam logic [31:0] LOCAL_BYTES = 32'(4 * REG_DEPTH);
    localparam logic [31:0] CH_BYTES    = 32'(NUM_CH * CH_STRIDE);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        LOCAL   = 5'b00010,
        CH_WAIT = 5'b00100,
        RESP    = 5'b01000,
        HOLD    = 5'b10000
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       regs_r [REG_DEPTH];
    logic              op_rd_r;
    logic              local_hit_r;
    logic [RI_W-1:0]   reg_idx_r;
    logic [CI_W-1:0]   ch_idx_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [31:0]       off_s;
    logic [31:0]       choff_s;
    logic              local_hit_s;
    logic              ch_hit_s;
    logic [CI_W-1:0]   ch_idx_s;
    logic              sel_ack_s;
    logic              timeout_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Address decode; unsigned wrap-around makes addresses below BASE_ADDR miss both windows.
    always_comb begin
        off_s       = (addr & ~32'd3) - BASE_ADDR;
        choff_s     = off_s - LOCAL_BYTES;
        local_hit_s = (off_s < LOCAL_BYTES);
        ch_hit_s    = !local_hit_s && (choff_s < CH_BYTES);
        ch_idx_s    = CI_W'(choff_s >> CA_W);
        sel_ack_s   = ch_ack[ch_idx_r];
        timeout_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ren || wen) begin
                    state_s = ch_hit_s ? CH_WAIT : LOCAL;
                end else begin
                    state_s = IDLE;
                end
            end
            LOCAL: state_s = RESP;
            CH_WAIT: begin
                if (sel_ack_s || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = CH_WAIT;
                end
            end
            RESP: state_s = HOLD;
            HOLD: begin
                if (!ren && !wen) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, register bank, channel handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= 32'd0;
            end
            op_rd_r     <= 1'b0;
            local_hit_r <= 1'b0;
            reg_idx_r   <= '0;
            ch_idx_r    <= '0;
            cnt_r       <= '0;
            ack         <= 1'b0;
            data_o      <= 32'd0;
            err         <= 1'b0;
            ch_req      <= '0;
            ch_we       <= 1'b0;
            ch_addr     <= '0;
            ch_wdata    <= 32'd0;
            ch_ben      <= 4'd0;
        end else begin
            ack <= (state_r == RESP);
            case (state_r)
                IDLE: begin
                    if (ren || wen) begin
                        op_rd_r     <= ren;
                        local_hit_r <= local_hit_s;
                        reg_idx_r   <= off_s[2 +: RI_W];
                        ch_idx_r    <= ch_idx_s;
                        cnt_r       <= '0;
                        ch_we       <= !ren;
                        ch_addr     <= choff_s[CA_W-1:0];
                        ch_wdata    <= data_i;
                        ch_ben      <= ben;
                        if (ch_hit_s) begin
                            ch_req <= NUM_CH'(1) << ch_idx_s;
                        end
                    end
                end
                LOCAL: begin
                    if (!local_hit_r) begin
                        err <= 1'b1;
                        if (op_rd_r) begin
                            data_o <= 32'd0;
                        end
                    end else if (op_rd_r) begin
                        err    <= 1'b0;
                        data_o <= regs_r[reg_idx_r];
                    end else begin
                        err               <= 1'b0;
                        regs_r[reg_idx_r] <= merge_bytes(regs_r[reg_idx_r], ch_wdata, ch_ben);
                    end
                end
                CH_WAIT: begin
                    // An ack landing on the timeout cycle still counts as success.
                    if (sel_ack_s) begin
                        ch_req <= '0;
                        err    <= 1'b0;
                        if (op_rd_r) begin
                            data_o <= ch_rdata[32*ch_idx_r +: 32];
                        end
                    end else if (timeout_s) begin
                        ch_req <= '0;
                        err    <= 1'b1;
                        if (op_rd_r) begin
                            data_o <= 32'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!ren && !wen) begin
                        err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomized self-checking bench for io_bus_ctrl against a transaction-level model.
module tb_io_bus_ctrl;

    localparam int          NUM_CH    = 2;
    localparam int          REG_DEPTH = 8;
    localparam int          CH_STRIDE = 16;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] BASE      = 32'h1F80_1000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [31:0]           addr = 32'd0;
    logic [31:0]           data_i = 32'd0;
    logic                  wen = 1'b0;
    logic                  ren = 1'b0;
    logic [3:0]            ben = 4'd0;
    logic                  ack;
    logic [31:0]           data_o;
    logic                  err;
    logic [NUM_CH-1:0]     ch_req;
    logic                  ch_we;
    logic [3:0]            ch_addr;
    logic [31:0]           ch_wdata;
    logic [3:0]            ch_ben;
    logic [NUM_CH-1:0]     ch_ack = '0;
    logic [32*NUM_CH-1:0]  ch_rdata = '0;

    io_bus_ctrl #(
        .NUM_CH(NUM_CH), .REG_DEPTH(REG_DEPTH), .BASE_ADDR(BASE),
        .CH_STRIDE(CH_STRIDE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_i(data_i), .wen(wen), .ren(ren),
        .ben(ben), .ack(ack), .data_o(data_o), .err(err), .ch_req(ch_req),
        .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ben(ch_ben),
        .ch_ack(ch_ack), .ch_rdata(ch_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mregs [REG_DEPTH];
    logic [31:0] mdata;
    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete CPU transaction; dly is the cycle index (0 = first wait cycle)
    // at which the selected channel acknowledges.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input int dly,
                          input logic [31:0] rdat, input int hold_extra);
        logic [31:0]       off;
        logic [31:0]       choff;
        int                kind;
        int                idx;
        int                k;
        logic [3:0]        cha;
        logic              exp_err;
        int                exp_lat;
        logic [NUM_CH-1:0] exp_req;
        logic              seen;
        int                lat;
        int                reqcyc;
        int                j;

        off = (a & ~32'd3) - BASE;
        choff = off - 32'(4 * REG_DEPTH);
        idx = 0; k = -1; cha = 4'd0;
        if (off < 32'(4 * REG_DEPTH)) begin
            kind = 0;
            idx = int'(off / 32'd4);
        end else if (choff < 32'(NUM_CH * CH_STRIDE)) begin
            kind = 1;
            k = int'(choff / 32'(CH_STRIDE));
            cha = 4'(choff % 32'(CH_STRIDE));
        end else begin
            kind = 2;
        end

        exp_err = 1'b0; exp_lat = 2; exp_req = '0;
        case (kind)
            0: begin
                if (rd) begin
                    mdata = mregs[idx];
                end else begin
                    for (int b = 0; b < 4; b++) if (be[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            1: begin
                exp_req[k] = 1'b1;
                if (dly <= TIMEOUT - 1) begin
                    exp_lat = dly + 2;
                    if (rd) mdata = rdat;
                end else begin
                    exp_lat = TIMEOUT + 1;
                    exp_err = 1'b1;
                    if (rd) mdata = 32'd0;
                end
            end
            default: begin
                exp_err = 1'b1;
                if (rd) mdata = 32'd0;
            end
        endcase

        @(negedge clk);
        addr = a; data_i = d; ben = be; ren = rd; wen = wr; ch_ack = '0;
        @(posedge clk);
        seen = 1'b0; lat = -1; reqcyc = 0; j = 0;
        while (!seen && j < 40) begin
            @(negedge clk);
            if (ack) begin
                seen = 1'b1;
                lat = j;
            end else begin
                if (j == 0) begin
                    check_eq("ch_req", 32'(ch_req), 32'(exp_req));
                    if (kind == 1) begin
                        check_eq("ch_we", 32'(ch_we), 32'(!rd));
                        check_eq("ch_addr", 32'(ch_addr), 32'(cha));
                        if (!rd) check_eq("ch_wdata", ch_wdata, d);
                        if (!rd) check_eq("ch_ben", 32'(ch_ben), 32'(be));
                    end
                end
                if (ch_req != '0) reqcyc++;
                for (int c = 0; c < NUM_CH; c++) begin
                    ch_ack[c] = (c == k) ? (j == dly) : 1'($urandom_range(0, 1));
                    ch_rdata[32*c +: 32] = (c == k) ? rdat : $urandom;
                end
                @(posedge clk);
                j++;
            end
        end
        ch_ack = '0;
        check_eq("ack_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("req_cycles", 32'(reqcyc), 32'((kind == 1) ? exp_lat - 1 : 0));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("data_o", data_o, mdata);
        for (int h = 0; h < hold_extra; h++) begin
            @(negedge clk);
            check_eq("ack_pulse_hold", 32'(ack), 32'd0);
            check_eq("err_hold", 32'(err), 32'(exp_err));
        end
        ren = 1'b0; wen = 1'b0;
        @(negedge clk);
        check_eq("ack_pulse", 32'(ack), 32'd0);
        check_eq("err_clear", 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  op;
        int          r;
        logic        stray;

        for (int i = 0; i < REG_DEPTH; i++) mregs[i] = 32'd0;
        mdata = 32'd0;
        #12;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_data_o", data_o, 32'd0);
        check_eq("rst_ch_req", 32'(ch_req), 32'd0);
        check_eq("rst_ch_we", 32'(ch_we), 32'd0);
        check_eq("rst_ch_addr", 32'(ch_addr), 32'd0);
        check_eq("rst_ch_wdata", ch_wdata, 32'd0);
        check_eq("rst_ch_ben", 32'(ch_ben), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_txn(1'b0, 1'b1, 32'h1F80_1004, 32'hAABB_CCDD, 4'b0101, 0, 32'd0, 0);
        do_txn(1'b1, 1'b0, 32'h1F80_1004, 32'd0, 4'hF, 0, 32'd0, 0);
        check_eq("reg1_value", data_o, 32'h00BB_00DD);
        do_txn(1'b1, 1'b0, 32'h1F80_1034, 32'd0, 4'hF, 3, 32'h1234_5678, 1);
        do_txn(1'b0, 1'b1, 32'h1F80_1020, 32'hCAFE_F00D, 4'hF, 1000, 32'd0, 0);
        do_txn(1'b1, 1'b0, 32'h1F80_1038, 32'd0, 4'hF, TIMEOUT - 1, 32'h0BAD_BEEF, 0);
        do_txn(1'b1, 1'b0, 32'h1F80_1040, 32'd0, 4'hF, 0, 32'd0, 0);
        do_txn(1'b1, 1'b1, 32'h1F80_1004, 32'h1111_1111, 4'hF, 0, 32'd0, 2);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      a = BASE + 32'($urandom_range(0, 4 * REG_DEPTH - 1));
            else if (r < 9) a = BASE + 32'(4 * REG_DEPTH) + 32'($urandom_range(0, NUM_CH * CH_STRIDE - 1));
            else            a = (t % 2 == 0) ? BASE - 32'd4 : BASE + 32'h40 + 32'($urandom_range(0, 255));
            op = 4'($urandom_range(1, 3));
            do_txn(op[0], op[1], a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, TIMEOUT + 3), $urandom, $urandom_range(0, 2));
        end

        // Reset in the middle of a channel wait.
        @(negedge clk);
        addr = 32'h1F80_1030; ren = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("wait_ch_req", 32'(ch_req), 32'b10);
        rst = 1'b1;
        #1;
        check_eq("rst_drops_req", 32'(ch_req), 32'd0);
        ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) stray = 1'b1;
        end
        check_eq("no_ack_after_rst", 32'(stray), 32'd0);
        for (int i = 0; i < REG_DEPTH; i++) mregs[i] = 32'd0;
        mdata = 32'd0;
        do_txn(1'b1, 1'b0, 32'h1F80_1000, 32'd0, 4'hF, 0, 32'd0, 0);
        do_txn(1'b1, 1'b0, 32'h1F80_1004, 32'd0, 4'hF, 0, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: external peripheral channels, 1..8.
REQ-002 Parameter REG_DEPTH, default 8: local 32-bit registers, power of 2, 1..64.
REQ-003 Parameter BASE_ADDR, default 32'h1F80_1000: byte base of the block's address window.
REQ-004 Parameter CH_STRIDE, default 16: bytes per channel window, power of 2, at least 4.
REQ-005 Parameter TIMEOUT, default 16: cycles allowed for a channel to acknowledge, at least 2.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 addr  input  32  CPU byte address; bits [1:0] ignored.
REQ-009 data_i  input  32  CPU write data.
REQ-010 wen, ren  input  1 each  CPU write and read requests, held high until ack is seen.
REQ-011 ben  input  4  byte enables; bit n qualifies data_i[8n+7:8n].
REQ-012 ack  output  1  one-cycle transaction-complete pulse.
REQ-013 data_o  output  32  read data.
REQ-014 err  output  1  error flag, valid while ack is high.
REQ-015 ch_req  output  NUM_CH  one-hot channel request.
REQ-016 ch_we  output  1  channel write strobe qualifier.
REQ-017 ch_addr  output  log2(CH_STRIDE)  byte offset within the channel window.
REQ-018 ch_wdata / ch_ben  output  32 / 4  captured write data and byte enables.
REQ-019 ch_ack  input  NUM_CH  channel completion, one bit per channel.
REQ-020 ch_rdata  input  32*NUM_CH  channel k read data in bits [32k+31:32k].

Function
REQ-021 Address map:
- Local register i is at BASE_ADDR+4i.
- Channel k window is BASE_ADDR+4*REG_DEPTH+k*CH_STRIDE, spanning CH_STRIDE bytes.
- Every other address is unmapped.
REQ-022 States: IDLE, LOCAL, CH_WAIT, RESP, HOLD; one-hot encoded.
REQ-023 IDLE behaviour:
- On ren or wen, capture addr, data_i, ben and the operation; ren wins if both are high.
- Go to CH_WAIT on a channel hit; otherwise go to LOCAL.
REQ-024 LOCAL, single cycle, then go to RESP:
- Local write updates only the enabled bytes.
- Local read loads data_o with the register.
- Unmapped access loads data_o=0, sets err=1 and leaves all registers unchanged.
REQ-025 CH_WAIT behaviour:
- Hold ch_req[k]=1 and ch_we/ch_addr/ch_wdata/ch_ben stable.
- Increment the wait counter each cycle.
REQ-026 In CH_WAIT, when ch_ack[k]=1, drop ch_req the next cycle and go to RESP; on a read, load data_o from ch_rdata slice k; err=0.
REQ-027 In CH_WAIT, if the counter reaches TIMEOUT-1 with no ack, drop ch_req, load data_o=0, set err=1 and go to RESP.
REQ-028 ch_ack[k] arriving in the same cycle as the timeout is treated as success.
REQ-029 ch_ack bits of non-selected channels are ignored.
REQ-030 RESP: assert ack=1 for exactly one cycle, then go to HOLD.
REQ-031 HOLD: stay until ren=0 and wen=0, then go to IDLE; err clears on leaving HOLD.
REQ-032 Local access latency: ack goes high 2 cycles after the IDLE sample.
REQ-033 Channel access latency: ack goes high 1 cycle after the state registers ch_ack.
REQ-034 Write transactions do not modify data_o.
REQ-035 data_o holds its value until the next read completes.
REQ-036 The block serves one transaction at a time; no new request is accepted outside IDLE.

Reset
REQ-037 On rst, asynchronously: state=IDLE; all local registers, data_o, ack, err, ch_req, ch_we, ch_addr, ch_wdata, ch_ben and the wait counter become 0.
REQ-038 Reset during CH_WAIT drops ch_req immediately and no ack is produced.

Verification
REQ-039 Default parameters:
- write 0x1F80_1004, data 0xAABBCCDD, ben=4'b0101 -> ack at cycle 2, reg1=0x00BB00DD.
- then read 0x1F80_1004 -> data_o=0x00BB00DD, err=0.
REQ-040 Read 0x1F80_1034 -> ch_req=2'b10, ch_addr=4, ch_we=0; bench drives ch_ack[1] after 3 cycles with 0x12345678 -> data_o=0x12345678, ack one cycle later.
REQ-041 Write 0x1F80_1020 with ch_ack never asserted -> ch_req[0] high for 16 cycles, then ack=1, err=1, data_o unchanged.
REQ-042 Read 0x1F80_1040 (unmapped) -> ack=1, err=1, data_o=0; ren and wen both high in IDLE -> read performed.
REQ-043 rst pulsed 2 cycles into CH_WAIT -> ch_req=0 immediately, no ack; the next read of 0x1F80_1000 returns 0.
